pdp11_operand_fetch: RTL
========================

// Module: pdp11_operand_fetch
// PURPOSE
//  Sequential operand-fetch engine for the PDP-11 core. It resolves all eight addressing modes (0-7)
//  for one source or destination specifier. It returns the operand value and its effective address.
//  It sits between instruction decode and execute, and drives the CPU register-file ports and the
//  data-memory port. It also performs register side effects: autoincrement, autodecrement and the
//  PC bump that follows an index-word fetch.
// PARAMETERS
//  DATA_WIDTH  16  register/memory word width
//  ADDR_WIDTH  16  memory address width (<= DATA_WIDTH)
//  NUM_REGS    8   register count; R[NUM_REGS-1]=PC, R[NUM_REGS-2]=SP
// PORTS
//  clk          in   1           single clock, rising edge
//  reset_n      in   1           asynchronous, active-low reset
//  start        in   1           1-cycle pulse: latch mode/reg_sel/byte_op, begin fetch
//  mode         in   3           addressing mode 0..7
//  reg_sel      in   $clog2(NUM_REGS)  register specifier Rn
//  byte_op      in   1           1 = byte access, 0 = word access
//  busy         out  1           high from the cycle after start until done
//  done         out  1           1-cycle pulse; operand/ea valid while done=1
//  operand      out  DATA_WIDTH  fetched value (byte: zero-extended, selected by ea[0])
//  ea           out  ADDR_WIDTH  effective address (mode 0: zero)
//  rf_rd_addr   out  $clog2(NUM_REGS)  register read address (combinational read)
//  rf_rd_data   in   DATA_WIDTH  register read data
//  rf_wr_en     out  1           register write strobe
//  rf_wr_addr   out  $clog2(NUM_REGS)  register write address
//  rf_wr_data   out  DATA_WIDTH  register write data
//  mem_req      out  1           memory read request; held high until mem_ack
//  mem_addr     out  ADDR_WIDTH  memory read address; stable while mem_req=1
//  mem_rdata    in   DATA_WIDTH  memory read data; valid when mem_ack=1
//  mem_ack      in   1           memory read complete
//  addr_trap    out  1           1-cycle pulse: word access to odd address (when enabled)
// BEHAVIOUR
//  Reset: all outputs are 0; FSM is IDLE; latched fields are cleared.
//  FSM states: IDLE, PREDEC, IDX_FETCH, PTR_FETCH, OPND_FETCH, DONE.
//  Transitions:
//   IDLE -start-> mode0: DONE; mode1/2/3: PTR_FETCH (mode 1/2 skip it, go OPND_FETCH);
//    mode4/5: PREDEC; mode6/7: IDX_FETCH.
//   PREDEC: one cycle; writes Rn-inc, then goes to OPND_FETCH (mode 4) or PTR_FETCH (mode 5).
//   IDX_FETCH: reads mem[PC] as X, writes PC+2, then sets ea=R+X. R is read after the PC update,
//    so X(PC) is relative to the next word. Next state is OPND_FETCH (6) or PTR_FETCH (7).
//   PTR_FETCH: pointer=mem[addr], then OPND_FETCH with ea=pointer.
//   OPND_FETCH: operand=mem[ea], then DONE.
//   DONE: done=1 for one cycle, then IDLE.
//  Step sizes: inc=1 for byte access, 2 for word access. It is always 2 for SP/PC, and for
//   pointer modes 3/5/7.
//  Mode 2/3 postincrement writes Rn+inc in the cycle the first address is latched.
//  Register arithmetic wraps modulo 2^DATA_WIDTH, e.g. 16'hFFFE+2 = 16'h0000.
//  Latency with zero-wait memory (mem_ack in the cycle after mem_req rises):
//   mode0=1, mode1/2=3, mode4=4, mode3/6=5, mode5=6, mode7=7 cycles from start to done.
//  Handshake: mem_req drops the cycle after mem_ack. mem_ack is ignored while mem_req=0.
//  start while busy=1 is ignored; it is not queued.
//  reset_n low mid-operation aborts immediately: mem_req=0, no further rf writes.
//   Register writes already performed are not undone.
//  operand/ea hold their last value after done until the next done.
// CONFIGURATION
//  ODD_ADDR_TRAP_EN defined:
//   - A word access whose address has bit0=1 is not issued.
//   - addr_trap pulses and the FSM returns to IDLE without done; no register writes occur after it.
//  ODD_ADDR_TRAP_EN undefined:
//   - addr_trap is tied to 0.
//   - Word addresses are forced even (bit0 cleared) and the access proceeds.
// TESTING
//  T1 mode0 R3=16'h1234, start -> done after 1 cycle, operand=16'h1234, no mem_req/rf_wr.
//  T2 mode2 word R1=16'h0100, mem[0100]=16'hBEEF -> operand=BEEF, ea=0100, R1=0102.
//  T2b mode2 byte, same setup -> R1=0101.
//  T3 mode5 R2=16'h0204, mem[0202]=0300, mem[0300]=16'h00AA -> R2=0202, operand=00AA,
//   ea=0300, done at cycle 6.
//  T4 mode6 PC=16'h1000, mem[1000]=0010, R4=0200, mem[0210]=5555 -> PC=1002, ea=0210, operand=5555.
//  T5 mode2 word R0=16'hFFFE -> R0 wraps to 0000. mem_ack delayed 3 cycles ->
//   mem_req and mem_addr held stable for all 3 cycles.
//  T6 mode1 R5=16'h0101, word: ODD_ADDR_TRAP_EN -> addr_trap pulse, no done;
//   without it -> mem_addr=0100. reset_n low during OPND_FETCH -> mem_req=0 next edge, IDLE.

Source files
------------

// File: rtl/pdp11_operand_fetch.sv
// pdp11_operand_fetch: sequential PDP-11 operand fetch for addressing modes 0-7, with register side effects.
//   clk, reset_n (async, active-low)
//   start/mode/reg_sel/byte_op : operand specifier and launch pulse
//   busy, done, operand, ea    : status and result (operand/ea hold until the next done)
//   rf_rd_addr/rf_rd_data      : register-file read port (combinational read)
//   rf_wr_en/addr/data         : register-file write port (autoinc/autodec, PC bump)
//   mem_req/addr/rdata/ack     : data-memory read handshake
//   addr_trap                  : odd word-address pulse, only when ODD_ADDR_TRAP_EN is defined;
//                                otherwise word addresses are forced even
module pdp11_operand_fetch #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_REGS   = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [2:0]                  mode,
    input  logic [$clog2(NUM_REGS)-1:0] reg_sel,
    input  logic                        byte_op,
    output logic                        busy,
    output logic                        done,
    output logic [DATA_WIDTH-1:0]       operand,
    output logic [ADDR_WIDTH-1:0]       ea,
    output logic [$clog2(NUM_REGS)-1:0] rf_rd_addr,
    input  logic [DATA_WIDTH-1:0]       rf_rd_data,
    output logic                        rf_wr_en,
    output logic [$clog2(NUM_REGS)-1:0] rf_wr_addr,
    output logic [DATA_WIDTH-1:0]       rf_wr_data,
    output logic                        mem_req,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    input  logic [DATA_WIDTH-1:0]       mem_rdata,
    input  logic                        mem_ack,
    output logic                        addr_trap
);
    localparam int RW = $clog2(NUM_REGS);
    localparam int HW = DATA_WIDTH / 2;
    localparam logic [RW-1:0] PC = RW'(NUM_REGS - 1);
    localparam logic [RW-1:0] SP = RW'(NUM_REGS - 2);

    typedef enum logic [2:0] {IDLE, PREDEC, IDX_FETCH, PTR_FETCH, OPND_FETCH, DONE} state_t;

    state_t state, nxt_state;
    logic [RW-1:0] rn_q, cur_rn, wr_addr;
    logic ptr_q, byte_q, cur_ptr, cur_byte, issue, nxt_word, wr_en, trap, sel_hi;
    logic [DATA_WIDTH-1:0] tmp, inc, base, nxt_addr, wr_val, src, opnd_val;

    // In IDLE the specifier comes straight from the inputs; afterwards from the latched copy.
    assign cur_rn   = (state == IDLE) ? reg_sel : rn_q;
    assign cur_ptr  = (state == IDLE) ? mode[0] : ptr_q;
    assign cur_byte = (state == IDLE) ? byte_op : byte_q;
    assign inc      = (cur_byte && cur_rn < SP && !cur_ptr) ? DATA_WIDTH'(1) : DATA_WIDTH'(2);
    // tmp holds the PC sampled at start; X(PC) must see the already-bumped PC.
    assign base     = (rn_q == PC) ? tmp + DATA_WIDTH'(2) : rf_rd_data;
    assign src      = (state == IDLE) ? rf_rd_data : mem_rdata;
    assign sel_hi   = (state != IDLE) && mem_addr[0];
    assign opnd_val = !cur_byte ? src : sel_hi ? DATA_WIDTH'(src[DATA_WIDTH-1:HW]) : DATA_WIDTH'(src[HW-1:0]);

    assign busy       = state != IDLE;
    assign done       = state == DONE;
    assign mem_req    = state == IDX_FETCH || state == PTR_FETCH || state == OPND_FETCH;
    assign rf_rd_addr = (state == IDLE && start) ? (mode[2:1] == 2'b11 ? PC : reg_sel) : rn_q;
    assign rf_wr_en   = wr_en && !trap;
    assign rf_wr_addr = rf_wr_en ? wr_addr : '0;
    assign rf_wr_data = rf_wr_en ? wr_val : '0;

`ifdef ODD_ADDR_TRAP_EN
    assign trap = issue && nxt_word && nxt_addr[0];
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        nxt_state = state;
        issue     = 1'b0;
        nxt_addr  = '0;
        nxt_word  = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = cur_rn;
        wr_val    = '0;
        case (state)
            IDLE: if (start) begin
                case (mode)
                    3'd0: nxt_state = DONE;
                    3'd1, 3'd2: begin
                        nxt_state = OPND_FETCH;
                        issue     = 1'b1;
                        nxt_addr  = rf_rd_data;
                        nxt_word  = !byte_op;
                    end
                    3'd3: begin
                        nxt_state = PTR_FETCH;
                        issue     = 1'b1;
                        nxt_addr  = rf_rd_data;
                    end
                    3'd4, 3'd5: nxt_state = PREDEC;
                    default: begin
                        nxt_state = IDX_FETCH;
                        issue     = 1'b1;
                        nxt_addr  = rf_rd_data;
                    end
                endcase
                wr_en  = mode == 3'd2 || mode == 3'd3;
                wr_val = rf_rd_data + inc;
            end
            PREDEC: begin
                nxt_state = ptr_q ? PTR_FETCH : OPND_FETCH;
                issue     = 1'b1;
                nxt_addr  = rf_rd_data - inc;
                nxt_word  = ptr_q || !byte_q;
                wr_en     = 1'b1;
                wr_val    = rf_rd_data - inc;
            end
            IDX_FETCH: if (mem_ack) begin
                nxt_state = ptr_q ? PTR_FETCH : OPND_FETCH;
                issue     = 1'b1;
                nxt_addr  = base + mem_rdata;
                nxt_word  = ptr_q || !byte_q;
                wr_en     = 1'b1;
                wr_addr   = PC;
                wr_val    = tmp + DATA_WIDTH'(2);
            end
            PTR_FETCH: if (mem_ack) begin
                nxt_state = OPND_FETCH;
                issue     = 1'b1;
                nxt_addr  = mem_rdata;
                nxt_word  = !byte_q;
            end
            OPND_FETCH: if (mem_ack) nxt_state = DONE;
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            rn_q      <= '0;
            ptr_q     <= 1'b0;
            byte_q    <= 1'b0;
            tmp       <= '0;
            mem_addr  <= '0;
            operand   <= '0;
            ea        <= '0;
            addr_trap <= 1'b0;
        end else begin
            addr_trap <= trap;
            state     <= trap ? IDLE : nxt_state;
            if (state == IDLE && start) begin
                rn_q   <= reg_sel;
                ptr_q  <= mode[0];
                byte_q <= byte_op;
                tmp    <= rf_rd_data;
            end
            if (issue && !trap)
                mem_addr <= nxt_word ? {nxt_addr[ADDR_WIDTH-1:1], 1'b0} : nxt_addr[ADDR_WIDTH-1:0];
            if (state == IDLE && start && mode == 3'd0) begin
                operand <= opnd_val;
                ea      <= '0;
            end
            if (state == OPND_FETCH && mem_ack) begin
                operand <= opnd_val;
                ea      <= mem_addr;
            end
        end
    end
endmodule
